// File: rtl/bounded_up_down_counter_if.sv
// Control and status bundle of the bounded up/down counter.
// No valid/ready here: every control input is sampled on each rising edge and every output is valid every cycle.
interface bounded_up_down_counter_if #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
);
  logic              clear_i;
  logic              load_i;
  logic [WIDTH-1:0]  load_val_i;
  logic              en_i;
  logic              up_i;
  logic              down_i;
  logic [STEP_W-1:0] step_i;
  logic              sat_i;
  logic [WIDTH-1:0]  count_o;
  logic              at_max_o;
  logic              at_min_o;
  logic              ovf_o;
  logic              unf_o;

  modport master (
    output clear_i, load_i, load_val_i, en_i, up_i, down_i, step_i, sat_i,
    input  count_o, at_max_o, at_min_o, ovf_o, unf_o
  );

  modport slave (
    input  clear_i, load_i, load_val_i, en_i, up_i, down_i, step_i, sat_i,
    output count_o, at_max_o, at_min_o, ovf_o, unf_o
  );
endinterface

// File: rtl/bounded_up_down_counter.sv
// Up/down counter confined to [MIN_VAL, MAX_VAL] with variable step, wrap or saturate,
// synchronous clear/load and one-cycle overflow/underflow pulses.
module bounded_up_down_counter #(
  parameter int WIDTH    = 8,
  parameter int MIN_VAL  = 0,
  parameter int MAX_VAL  = 2**WIDTH-1,
  parameter int STEP_W   = 4,
  parameter int INIT_VAL = MIN_VAL
) (
  input  logic                      clk_i,
  input  logic                      arst_i,
  bounded_up_down_counter_if.slave  bus
);

  localparam int RANGE = MAX_VAL - MIN_VAL + 1;

  // Parameter sanity, caught at elaboration.
  if (!(MIN_VAL >= 0 && MIN_VAL < MAX_VAL && MAX_VAL <= 2**WIDTH-1)) begin : g_bad_bounds
    $error("bounded_up_down_counter: need 0 <= MIN_VAL < MAX_VAL <= 2**WIDTH-1");
  end
  if ((2**STEP_W - 1) > RANGE) begin : g_bad_step
    $error("bounded_up_down_counter: 2**STEP_W-1 must not exceed MAX_VAL-MIN_VAL+1");
  end
  if (INIT_VAL < MIN_VAL || INIT_VAL > MAX_VAL) begin : g_bad_init
    $error("bounded_up_down_counter: INIT_VAL must lie in [MIN_VAL, MAX_VAL]");
  end

  // Two guard bits keep count+step and count-step exact, including negative differences.
  typedef logic signed [WIDTH+1:0] wide_t;

  localparam wide_t            MIN_W   = wide_t'(MIN_VAL);
  localparam wide_t            MAX_W   = wide_t'(MAX_VAL);
  localparam wide_t            RANGE_W = wide_t'(RANGE);
  localparam logic [WIDTH-1:0] MIN_C   = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MAX_C   = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] INIT_C  = WIDTH'(INIT_VAL);

  logic [WIDTH-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  wide_t            cur_w, step_w, sum_w, diff_w;

  assign cur_w  = wide_t'({2'b00, count_q});
  assign step_w = wide_t'({{(WIDTH+2-STEP_W){1'b0}}, bus.step_i});
  assign sum_w  = cur_w + step_w;
  assign diff_w = cur_w - step_w;

  always_comb begin
    count_d = count_q;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    if (bus.clear_i) begin
      count_d = INIT_C;
    end else if (bus.load_i) begin
      if (bus.load_val_i < MIN_C)      count_d = MIN_C;
      else if (bus.load_val_i > MAX_C) count_d = MAX_C;
      else                             count_d = bus.load_val_i;
    end else if (bus.en_i && (bus.up_i != bus.down_i) && (bus.step_i != '0)) begin
      if (bus.up_i) begin
        if (sum_w > MAX_W) begin
          ovf_d   = 1'b1;
          count_d = bus.sat_i ? MAX_C : WIDTH'(sum_w - RANGE_W);
        end else begin
          count_d = WIDTH'(sum_w);
        end
      end else begin
        if (diff_w < MIN_W) begin
          unf_d   = 1'b1;
          count_d = bus.sat_i ? MIN_C : WIDTH'(diff_w + RANGE_W);
        end else begin
          count_d = WIDTH'(diff_w);
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      count_q <= INIT_C;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign bus.count_o  = count_q;
  assign bus.ovf_o    = ovf_q;
  assign bus.unf_o    = unf_q;
  assign bus.at_max_o = (count_q == MAX_C);
  assign bus.at_min_o = (count_q == MIN_C);

endmodule
